// File: rtl/shift_pkg.sv
// Shared constants and types for the shift datapath and its two-port arbiter.
package shift_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_LSL  = 2'b00;
    localparam logic [OP_W-1:0] OP_LSR  = 2'b01;
    localparam logic [OP_W-1:0] OP_ASR  = 2'b10;
    localparam logic [OP_W-1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] data;
    } shift_req_t;

endpackage

// File: rtl/shift.sv
// Combinational 32-bit shifter with one-hot left/right/math_shift controls and carry out.
module shift
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] src,
    input  logic [DATA_W-1:0] dst,
    input  logic              left,
    input  logic              right,
    input  logic              math_shift,
    output logic [DATA_W-1:0] result_c,
    output logic              cf_c
);

    logic [AMT_W-1:0]       amt;
    logic [DATA_W:0]        lsl_ext;
    logic [DATA_W:0]        lsr_ext;
    logic signed [DATA_W:0] asr_ext;
    logic                   unused_src_bits;

    assign amt             = src[AMT_W-1:0];
    assign unused_src_bits = ^src[DATA_W-1:AMT_W];

    // One guard bit beside the operand catches the last bit shifted out; amt==0 leaves it 0.
    assign lsl_ext = {1'b0, dst} << amt;
    assign lsr_ext = {dst, 1'b0} >> amt;
    assign asr_ext = $signed({dst, 1'b0}) >>> amt;

    always_comb begin
        result_c = '0;
        cf_c     = 1'b0;
        if (left) begin
            result_c = lsl_ext[DATA_W-1:0];
            cf_c     = lsl_ext[DATA_W];
        end else if (right) begin
            result_c = lsr_ext[DATA_W:1];
            cf_c     = lsr_ext[0];
        end else if (math_shift) begin
            result_c = asr_ext[DATA_W:1];
            cf_c     = asr_ext[0];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port valid/ready front end sharing one shift datapath; one operation in flight.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_amt,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_amt,
    input  logic [DATA_W-1:0] req1_data,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_cf,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_cf,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    shift_req_t        cap_q, cap_d;
    logic [DATA_W-1:0] res0_q, res0_d, res1_q, res1_d;
    logic              cf0_q, cf0_d, cf1_q, cf1_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic              busy_q, busy_d;

    logic              grant1_c;
    logic              idle_c;
    logic              resp_hs_c;
    shift_req_t        req_sel_c;
    logic [DATA_W-1:0] sh_result_c;
    logic              sh_cf_c;
    logic              unused_amt_bits;

    assign unused_amt_bits = ^{req0_amt[DATA_W-1:AMT_W], req1_amt[DATA_W-1:AMT_W]};

    // Port 1 wins when it is alone, or on a tie when the round-robin pointer favours it.
    assign grant1_c   = req1_valid & (~req0_valid | (ROUND_ROBIN & rr_q));
    assign idle_c     = (state_q == ST_IDLE);
    assign req0_ready = idle_c & req0_valid & ~grant1_c;
    assign req1_ready = idle_c & grant1_c;

    assign req_sel_c = grant1_c
        ? '{op: req1_op, amt: req1_amt[AMT_W-1:0], data: req1_data}
        : '{op: req0_op, amt: req0_amt[AMT_W-1:0], data: req0_data};

    assign resp_hs_c = owner_q ? (rv1_q & resp1_ready) : (rv0_q & resp0_ready);

    shift u_shift (
        .src        (DATA_W'(cap_q.amt)),
        .dst        (cap_q.data),
        .left       (cap_q.op == OP_LSL),
        .right      (cap_q.op == OP_LSR),
        .math_shift (cap_q.op == OP_ASR),
        .result_c   (sh_result_c),
        .cf_c       (sh_cf_c)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cap_d   = cap_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        cf0_d   = cf0_q;
        cf1_d   = cf1_q;
        rv0_d   = rv0_q;
        rv1_d   = rv1_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_ready | req1_ready) begin
                    owner_d = grant1_c;
                    cap_d   = req_sel_c;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (owner_q) begin
                    res1_d = sh_result_c;
                    cf1_d  = sh_cf_c;
                    rv1_d  = 1'b1;
                end else begin
                    res0_d = sh_result_c;
                    cf0_d  = sh_cf_c;
                    rv0_d  = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Pointer moves to the non-owner so a continuous loser is served next.
                if (resp_hs_c) begin
                    rv0_d   = 1'b0;
                    rv1_d   = 1'b0;
                    busy_d  = 1'b0;
                    rr_d    = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rv0_d   = 1'b0;
                rv1_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            cap_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            cf0_q   <= 1'b0;
            cf1_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cap_q   <= cap_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            cf0_q   <= cf0_d;
            cf1_q   <= cf1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            busy_q  <= busy_d;
        end
    end

    assign resp0_valid  = rv0_q;
    assign resp1_valid  = rv1_q;
    assign resp0_result = res0_q;
    assign resp1_result = res1_q;
    assign resp0_cf     = cf0_q;
    assign resp1_cf     = cf1_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vectors, random ops against a bit-serial model, arbitration corners.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_amt = '0, req1_amt = '0, req0_data = '0, req1_data = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_cf, resp1_cf, busy;

    wire [1:0] req_ready  = {req1_ready, req0_ready};
    wire [1:0] resp_valid = {resp1_valid, resp0_valid};

    int n_checks = 0;
    int n_errors = 0;
    bit rr_exp   = 1'b0;

    always #5 clk = ~clk;

    shift_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_amt(req0_amt), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_amt(req1_amt), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_cf(resp0_cf),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_cf(resp1_cf),
        .busy(busy)
    );

    typedef struct {
        bit          p;
        logic [1:0]  op;
        logic [31:0] amt;
        logic [31:0] data;
        logic [31:0] res;
        logic        cf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one bit per step, carry is whatever fell off the end.
    task automatic ref_shift(input logic [1:0] op, input logic [31:0] amt, input logic [31:0] data,
                             output logic [31:0] res, output logic cf);
        int n;
        n   = int'(amt % 32);
        res = data;
        cf  = 1'b0;
        if (op == 2'b11) begin
            res = '0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (op == 2'b00) begin
                    cf  = res[31];
                    res = res << 1;
                end else begin
                    cf  = res[0];
                    res = {(op == 2'b10) ? res[31] : 1'b0, res[31:1]};
                end
            end
        end
    endtask

    function automatic logic [31:0] get_res(input bit p);
        return p ? resp1_result : resp0_result;
    endfunction

    function automatic logic get_cf(input bit p);
        return p ? resp1_cf : resp0_cf;
    endfunction

    task automatic drive(input bit p, input logic v, input logic [1:0] op,
                         input logic [31:0] amt, input logic [31:0] data);
        if (p) begin
            req1_valid = v; req1_op = op; req1_amt = amt; req1_data = data;
        end else begin
            req0_valid = v; req0_op = op; req0_amt = amt; req0_data = data;
        end
    endtask

    // Issue one op; returns mid-cycle T+2 with the response checked but not yet consumed.
    task automatic issue(input bit p, input logic [1:0] op, input logic [31:0] amt,
                         input logic [31:0] data, input logic [31:0] exp_res, input logic exp_cf);
        int waited;
        @(negedge clk);
        drive(p, 1'b1, op, amt, data);
        waited = 0;
        #1;
        while (!req_ready[p] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("req_ready", 32'(req_ready[p]), 32'd1);
        if (!req_ready[p]) begin
            drive(p, 1'b0, op, amt, data);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drive(p, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk("resp_valid_t1", 32'(resp_valid[p]), 32'd0);
        chk("busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("resp_valid_t2", 32'(resp_valid[p]), 32'd1);
        chk("other_resp_valid", 32'(resp_valid[~p]), 32'd0);
        chk("result", get_res(p), exp_res);
        chk("cf", 32'(get_cf(p)), 32'(exp_cf));
        rr_exp = ~p;
    endtask

    initial begin
        logic [31:0] er;
        logic        ec;
        int          g_port[4];
        int          g_cyc[4];
        int          ng;

        vecs[0] = '{1'b0, 2'b00, 32'd1,    32'h8000_0001, 32'h0000_0002, 1'b1};
        vecs[1] = '{1'b1, 2'b01, 32'h21,   32'h0000_0003, 32'h0000_0001, 1'b1};
        vecs[2] = '{1'b0, 2'b10, 32'd4,    32'h8000_0000, 32'hF800_0000, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 32'd0,    32'h0000_1234, 32'h0000_1234, 1'b0};
        vecs[4] = '{1'b1, 2'b00, 32'd31,   32'h0000_0003, 32'h8000_0000, 1'b1};
        vecs[5] = '{1'b0, 2'b01, 32'd31,   32'h8000_0000, 32'h0000_0001, 1'b0};
        vecs[6] = '{1'b1, 2'b10, 32'd31,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{1'b1, 2'b11, 32'd5,    32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        // Reset values
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_result0", resp0_result, 32'd0);
        chk("rst_result1", resp1_result, 32'd0);
        chk("rst_cf", 32'({resp1_cf, resp0_cf}), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            issue(vecs[i].p, vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].res, vecs[i].cf);

        for (int i = 0; i < 40; i++) begin
            bit          p;
            logic [1:0]  op;
            logic [31:0] amt, data;
            p    = 1'($urandom_range(0, 1));
            op   = 2'($urandom_range(0, 3));
            amt  = (i % 8 == 0) ? 32'h20 * $urandom_range(0, 7) : $urandom;
            data = $urandom;
            ref_shift(op, amt, data, er, ec);
            issue(p, op, amt, data, er, ec);
        end

        // Round robin with both ports continuously requesting
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 32'd1, 32'h11);
        drive(1'b1, 1'b1, 2'b01, 32'd1, 32'h22);
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) chk("rr_both_ready", 32'(req_ready), 32'd1);
            if (req0_ready || req1_ready) begin
                g_port[ng] = req1_ready ? 1 : 0;
                g_cyc[ng]  = c;
                ng++;
            end
            if (ng < 4) @(negedge clk);
        end
        chk("rr_grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < ng; k++) begin
            chk("rr_grant_port", 32'(g_port[k]), 32'(rr_exp ^ k[0]));
            if (k > 0) chk("rr_interval", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
        end
        if (ng > 0) rr_exp = ~g_port[ng-1][0];
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Backpressure on port 0 while port 1 waits
        resp0_ready = 1'b0;
        ref_shift(2'b10, 32'd4, 32'h8000_00F8, er, ec);
        issue(1'b0, 2'b10, 32'd4, 32'h8000_00F8, er, ec);
        drive(1'b1, 1'b1, 2'b00, 32'd3, 32'h1000_0001);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_resp0_valid", 32'(resp0_valid), 32'd1);
            chk("bp_result", resp0_result, er);
            chk("bp_cf", 32'(resp0_cf), 32'(ec));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_resp0_drop", 32'(resp0_valid), 32'd0);
        chk("bp_req1_granted", 32'(req1_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        ref_shift(2'b00, 32'd3, 32'h1000_0001, er, ec);
        chk("bp_resp1_valid", 32'(resp1_valid), 32'd1);
        chk("bp_resp1_result", resp1_result, er);
        chk("bp_resp1_cf", 32'(resp1_cf), 32'(ec));

        // Reserved op on port 0 leaves the pointer favouring port 1
        issue(1'b0, 2'b11, 32'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);

        // Reset during EXEC aborts the op
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 32'd2, 32'h0000_00FF);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_result0", resp0_result, 32'd0);
        chk("arst_result1", resp1_result, 32'd0);
        chk("arst_cf", 32'({resp1_cf, resp0_cf}), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 32'd1, 32'h1);
        drive(1'b1, 1'b1, 2'b00, 32'd1, 32'h2);
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b01);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
